// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Streams a program image from a byte-wide valid/ready source into a word
// memory, holding the CPU in reset until the image is complete.
//
// Stream format: header byte N (word count, 0-255), followed by N words of
// two bytes each, high byte first. Word k is written to (LOAD_BASE + k) with
// 8-bit wrap.
//
// Optional build: define PROG_LOADER_CHECKSUM_EN to XOR every data byte into
// an 8-bit checksum. One trailing byte is then expected after the last word.
// A match releases the CPU. A mismatch parks the loader in ERR with o_err set.
//
// Parameters:
//   BITS       memory word width; must be 16
//   LOAD_BASE  address of the first word written
//
// Ports:
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous active-high reset
//   i_valid     upstream byte valid
//   i_byte      upstream byte
//   o_ready     loader accepts a byte this cycle
//   o_mem_we    memory write strobe, one cycle per word
//   o_mem_addr  memory write address
//   o_mem_data  memory write word
//   o_cpu_rst   holds the CPU in reset while high
//   o_done      image loaded, CPU released
//   o_err       checksum mismatch (always 0 without the checksum build)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int         BITS      = 16,
    parameter logic [7:0] LOAD_BASE = 8'h00
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [7:0]      i_byte,
    output logic            o_ready,
    output logic            o_mem_we,
    output logic [7:0]      o_mem_addr,
    output logic [BITS-1:0] o_mem_data,
    output logic            o_cpu_rst,
    output logic            o_done,
    output logic            o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HI,
        ST_LO,
        ST_WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_DONE,
        ST_ERR
    } state_t;

    // State entered once the last word has been written, or straight from
    // the header when N is 0.
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_LOAD = ST_CHK;
`else
    localparam state_t ST_AFTER_LOAD = ST_DONE;
`endif

    state_t          state_q, state_d;
    logic [7:0]      n_q, n_d;
    logic [7:0]      idx_q, idx_d;
    logic [BITS-1:0] data_q, data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      chk_q, chk_d;
    logic            err_q, err_d;
`endif

    // Outputs are registered and computed from the next state. This keeps
    // i_valid off the o_ready path.
    logic            ready_q, ready_d;
    logic            mem_we_q, mem_we_d;
    logic [7:0]      mem_addr_q, mem_addr_d;
    logic [BITS-1:0] mem_data_q, mem_data_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;

    logic            xfer;

    assign xfer = i_valid && ready_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first. Without
        // that, any path that skips an assignment infers a latch.
        state_d = state_q;
        n_d     = n_q;
        idx_d   = idx_q;
        data_d  = data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    n_d     = i_byte;
                    idx_d   = 8'h00;
                    state_d = (i_byte == 8'h00) ? ST_AFTER_LOAD : ST_HI;
                end
            end
            ST_HI: begin
                if (xfer) begin
                    data_d[15:8] = i_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ i_byte;
`endif
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (xfer) begin
                    data_d[7:0] = i_byte;
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ i_byte;
`endif
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // The write strobe is high for this single cycle. Advance to
                // the next word index on the way out.
                idx_d   = idx_q + 8'h01;
                state_d = (idx_d == n_q) ? ST_AFTER_LOAD : ST_HI;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (xfer) begin
                    state_d = (i_byte == chk_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE:  state_d = ST_DONE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase

        // Output decode from the next state
        ready_d = (state_d == ST_IDLE) || (state_d == ST_HI) ||
                  (state_d == ST_LO);
`ifdef PROG_LOADER_CHECKSUM_EN
        ready_d = ready_d || (state_d == ST_CHK);
        err_d   = (state_d == ST_ERR);
`endif
        mem_we_d   = (state_d == ST_WRITE);
        mem_addr_d = LOAD_BASE + idx_d;     // 8-bit wrap is intended
        mem_data_d = data_d;
        cpu_rst_d  = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // flop then samples pre-edge values, whatever the statement order.
        if (i_rst) begin
            state_q    <= ST_IDLE;
            n_q        <= 8'h00;
            idx_q      <= 8'h00;
            data_q     <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q      <= 8'h00;
            err_q      <= 1'b0;
`endif
            ready_q    <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= LOAD_BASE;
            mem_data_q <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
            err_q      <= err_d;
`endif
            ready_q    <= ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_mem_we   = mem_we_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;
    assign o_cpu_rst  = cpu_rst_q;
    assign o_done     = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign o_err      = err_q;
`else
    assign o_err      = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Directed bench for prog_loader. Two instances share one input stream:
//   - dut0 uses LOAD_BASE = 00
//   - dutf uses LOAD_BASE = FF, which exercises the address wrap
// Writes from each instance are captured into a queue. The queues are then
// compared against hand-computed address/data pairs.
// Checksum-build stimulus is enabled by PROG_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int HS_LIMIT = 40;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  byte_in;

    logic        ready0, we0, cpu_rst0, done0, err0;
    logic [7:0]  addr0;
    logic [15:0] data0;
    logic        readyf, wef, cpu_rstf, donef, errf;
    logic [7:0]  addrf;
    logic [15:0] dataf;

    logic [23:0] wr0[$];
    logic [23:0] wrf[$];

    int n_tests = 0;
    int n_fail  = 0;

    prog_loader #(.BITS(16), .LOAD_BASE(8'h00)) dut0 (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_byte    (byte_in),
        .o_ready   (ready0),
        .o_mem_we  (we0),
        .o_mem_addr(addr0),
        .o_mem_data(data0),
        .o_cpu_rst (cpu_rst0),
        .o_done    (done0),
        .o_err     (err0)
    );

    prog_loader #(.BITS(16), .LOAD_BASE(8'hFF)) dutf (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_byte    (byte_in),
        .o_ready   (readyf),
        .o_mem_we  (wef),
        .o_mem_addr(addrf),
        .o_mem_data(dataf),
        .o_cpu_rst (cpu_rstf),
        .o_done    (donef),
        .o_err     (errf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe, sampled away from the rising edge
    always @(negedge clk) begin
        if (we0) wr0.push_back({addr0, data0});
        if (wef) wrf.push_back({addrf, dataf});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr0.delete();
        wrf.delete();
    endtask

    // Offers one byte. Returns at the falling edge right after it transfers.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited  = 0;
        valid   = 1'b1;
        byte_in = b;
        while (!ready0 && waited < HS_LIMIT) begin
            @(negedge clk);
            waited++;
        end
        check("handshake_wait", (waited >= HS_LIMIT) ? 32'd1 : 32'd0, 32'd0);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic check_wr(input string tag, input int idx,
                            input logic [23:0] exp0, input logic [23:0] expf);
        logic [31:0] got0, gotf;
        got0 = (idx < wr0.size()) ? {8'h00, wr0[idx]} : 32'hDEAD_BEEF;
        gotf = (idx < wrf.size()) ? {8'h00, wrf[idx]} : 32'hDEAD_BEEF;
        check({tag, "_base00"}, got0, {8'h00, exp0});
        check({tag, "_baseFF"}, gotf, {8'h00, expf});
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},    {31'd0, done0},    32'd1);
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst0}, 32'd0);
        check({tag, "_ready"},   {31'd0, ready0},   32'd0);
        check({tag, "_err"},     {31'd0, err0},     32'd0);
        check({tag, "_done_ff"}, {31'd0, donef},    32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        valid   = 1'b0;
        byte_in = 8'h00;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_ready",    {31'd0, ready0},   32'd1);
        check("rst_we",       {31'd0, we0},      32'd0);
        check("rst_addr0",    {24'd0, addr0},    32'h00);
        check("rst_addrf",    {24'd0, addrf},    32'hFF);
        check("rst_data",     {16'd0, data0},    32'h0);
        check("rst_cpu_rst",  {31'd0, cpu_rst0}, 32'd1);
        check("rst_done",     {31'd0, done0},    32'd0);
        check("rst_err",      {31'd0, err0},     32'd0);

        // ---------------- two-word load, back to back ----------------
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'hAB);
        send_byte(8'hCD);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h40);                // 12^34^AB^CD
`endif
        repeat (3) @(negedge clk);
        check("load2_count0", wr0.size(), 32'd2);
        check("load2_countf", wrf.size(), 32'd2);
        check_wr("load2_w0", 0, 24'h00_1234, 24'hFF_1234);
        check_wr("load2_w1", 1, 24'h01_ABCD, 24'h00_ABCD);
        check_done("load2");

        // Bytes offered in DONE are ignored
        valid   = 1'b1;
        byte_in = 8'h77;
        repeat (4) @(negedge clk);
        valid = 1'b0;
        check("done_hold_ready", {31'd0, ready0}, 32'd0);
        check("done_hold_count", wr0.size(), 32'd2);
        check("done_hold_done",  {31'd0, done0},  32'd1);

        // ---------------- empty image ----------------
        do_reset();
        send_byte(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
        check("empty_chk_ready", {31'd0, ready0},   32'd1);
        check("empty_chk_done",  {31'd0, done0},    32'd0);
        check("empty_chk_cpu",   {31'd0, cpu_rst0}, 32'd1);
        send_byte(8'h00);
`endif
        check("empty_done",    {31'd0, done0},    32'd1);
        check("empty_cpu_rst", {31'd0, cpu_rst0}, 32'd0);
        repeat (2) @(negedge clk);
        check("empty_no_write", wr0.size(), 32'd0);

        // ---------------- stalled source ----------------
        do_reset();
        begin
            logic [7:0] stream [5];
            stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
            for (int i = 0; i < 5; i++) begin
                valid = 1'b0;
                repeat (5) @(negedge clk);
                check("stall_ready", {31'd0, ready0}, 32'd1);
                send_byte(stream[i]);
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        repeat (5) @(negedge clk);
        send_byte(8'h40);
`endif
        repeat (3) @(negedge clk);
        check("stall_count", wr0.size(), 32'd2);
        check_wr("stall_w0", 0, 24'h00_1234, 24'hFF_1234);
        check_wr("stall_w1", 1, 24'h01_ABCD, 24'h00_ABCD);
        check_done("stall");

        // ---------------- reset mid-load ----------------
        do_reset();
        send_byte(8'h03);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cpu_rst", {31'd0, cpu_rst0}, 32'd1);
        check("midrst_done",    {31'd0, done0},    32'd0);
        check("midrst_ready",   {31'd0, ready0},   32'd1);
        check("midrst_data",    {16'd0, data0},    32'h0);
        rst = 1'b0;
        send_byte(8'h01);
        send_byte(8'h55);
        send_byte(8'h66);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h33);                // 55^66
`endif
        repeat (3) @(negedge clk);
        check("midrst_count", wr0.size(), 32'd2);
        check_wr("midrst_w0", 0, 24'h00_1234, 24'hFF_1234);
        check_wr("midrst_w1", 1, 24'h00_5566, 24'hFF_5566);
        check_done("midrst");

`ifdef PROG_LOADER_CHECKSUM_EN
        // ---------------- checksum match / mismatch ----------------
        do_reset();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h26);
        check_done("chk_ok");

        do_reset();
        send_byte(8'h01);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h27);
        check("chk_bad_err",     {31'd0, err0},     32'd1);
        check("chk_bad_cpu_rst", {31'd0, cpu_rst0}, 32'd1);
        check("chk_bad_done",    {31'd0, done0},    32'd0);
        check("chk_bad_ready",   {31'd0, ready0},   32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The module SHALL have parameter BITS, default 16: memory word width; BITS SHALL be 16.
REQ-002 The module SHALL have parameter LOAD_BASE, default 8'h00: first memory address written.
REQ-003 The module SHALL have port i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port i_valid  input  1  upstream byte valid.
REQ-006 The module SHALL have port i_byte  input  8  upstream byte.
REQ-007 The module SHALL have port o_ready  output  1  loader accepts a byte this cycle.
REQ-008 The module SHALL have port o_mem_we  output  1  memory write strobe, one cycle per word.
REQ-009 The module SHALL have port o_mem_addr  output  8  memory write address.
REQ-010 The module SHALL have port o_mem_data  output  BITS  memory write word.
REQ-011 The module SHALL have port o_cpu_rst  output  1  holds the CPU in reset while high.
REQ-012 The module SHALL have port o_done  output  1  image loaded; CPU released.
REQ-013 The module SHALL have port o_err  output  1  load failed (checksum build only).

Function
REQ-014 A byte SHALL transfer only on a rising edge where i_valid and o_ready are both high; all outputs SHALL decode from registered state, with no combinational path from i_valid to o_ready.
REQ-015 The stream format SHALL be: header byte N (word count, 0-255), then N words sent as 2 bytes each, high byte first.
REQ-016 The FSM SHALL have states IDLE, HI, LO, WRITE, CHK, DONE and ERR; o_ready SHALL be high only in IDLE, HI, LO and CHK.
REQ-017 On a transfer in IDLE, the FSM SHALL latch N and clear the word index; if N=0 it SHALL go to CHK (checksum build) or DONE, otherwise to HI.
REQ-018 On a transfer in HI, the FSM SHALL latch data[15:8] and go to LO.
REQ-019 On a transfer in LO, the FSM SHALL latch data[7:0] and go to WRITE.
REQ-020 In WRITE, for exactly one cycle, o_mem_we SHALL be 1, o_mem_addr SHALL be (LOAD_BASE + index) mod 256 with 8-bit wrap, and o_mem_data SHALL be the assembled word.
REQ-021 On leaving WRITE, the index SHALL increment; if the index equals N the FSM SHALL go to CHK or DONE, otherwise to HI.
REQ-022 A stalled i_valid in any accepting state SHALL hold the state and all latched data indefinitely.
REQ-023 o_cpu_rst SHALL be 1 in every state except DONE; in DONE, o_done SHALL be 1 and o_cpu_rst SHALL be 0.
REQ-024 DONE and ERR SHALL be terminal until i_rst; bytes offered in these states SHALL be ignored (o_ready=0).
REQ-025 o_mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-026 While i_rst is high at a clock edge, the FSM SHALL enter IDLE, with index, N, data and checksum cleared to 0.
REQ-027 Post-reset outputs SHALL be: o_ready=1, o_mem_we=0, o_mem_addr=LOAD_BASE, o_mem_data=0, o_cpu_rst=1, o_done=0, o_err=0.
REQ-028 A reset asserted mid-load SHALL abandon the load; words already written SHALL remain in memory, and the next byte accepted SHALL be treated as a header.

Configuration
REQ-029 With macro PROG_LOADER_CHECKSUM_EN defined, the module SHALL XOR every accepted data byte (not the header) into an 8-bit checksum.
REQ-030 In that build, the CHK state SHALL accept one trailing byte; if it equals the checksum the FSM SHALL go to DONE, otherwise to ERR, where o_err=1 and o_cpu_rst=1.
REQ-031 Without PROG_LOADER_CHECKSUM_EN, the CHK state and the checksum register SHALL be absent, and o_err SHALL be tied to 0.

Verification
REQ-032 The bench SHALL send bytes 02,12,34,AB,CD with LOAD_BASE=0 and require writes 00<-1234 and 01<-ABCD, then o_done=1 and o_cpu_rst=0.
REQ-033 The bench SHALL send header 00 and require no o_mem_we pulse, then DONE on the next edge (or CHK in the checksum build).
REQ-034 The bench SHALL use LOAD_BASE=FF, N=2 and require write addresses FF then 00 (wrap).
REQ-035 The bench SHALL drop i_valid for 5 cycles between bytes and require an identical write sequence, with o_ready held high and no duplicated write.
REQ-036 The bench SHALL assert i_rst after the first word of a 3-word load and require o_cpu_rst=1 and o_done=0; a following header 01 and bytes 55,66 SHALL then write LOAD_BASE<-5566.
REQ-037 In the checksum build, the bench SHALL send 01,12,34 then trailing byte 26 and require DONE; trailing byte 27 SHALL give o_err=1 and o_cpu_rst=1.
